// File: rtl/obstacle_scroller_if.sv
// Control and frame bus between the obstacle scroller and its consumers.
interface obstacle_scroller_if #(
  parameter int ROWS = 7,
  parameter int COLS = 5
);
  logic                 enable;
  logic                 clear;
  logic [ROWS*COLS-1:0] data_flat;
  logic                 step_pulse;
  logic [7:0]           passed_count;
  logic [3:0]           speed_level;

  modport master (
    output enable, clear,
    input  data_flat, step_pulse, passed_count, speed_level
  );

  modport slave (
    input  enable, clear,
    output data_flat, step_pulse, passed_count, speed_level
  );
endinterface

// File: rtl/obstacle_scroller.sv
// Scrolling obstacle field for the Dino Game LED matrix: spawns shapes at row1,
// shifts toward the exit row each step, counts passed obstacles and speeds up.
module obstacle_scroller #(
  parameter int          ROWS          = 7,
  parameter int          COLS          = 5,
  parameter int          TICK_DIV      = 5000000,
  parameter int          MIN_DIV       = 1000000,
  parameter int          SPEEDUP_STEP  = 250000,
  parameter int          SPEEDUP_EVERY = 8,
  parameter int          GAP_MIN       = 2,
  parameter int          RANDOM        = 0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               MAX10_CLK1_50,
  input  logic               KEY0,
  obstacle_scroller_if.slave bus
);
  localparam logic [0:0] ST_GAP  = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [ROWS-1:0][COLS-1:0] field;
  logic [31:0]               tick_cnt, period, sub;
  logic [15:0]               lfsr, lfsr_next;
  logic [0:0]                state;
  logic [7:0]                gap_cnt, next_gap, every_cnt, passed_count;
  logic [3:0]                speed_level;
  logic [1:0]                type_idx, shape, emit_idx, shape_len;
  logic [COLS-1:0]           entry;
  logic                      step, pass;

  // Period only depends on speed_level, which changes on a step (counter = 0),
  // so the new period naturally starts with the next count cycle.
  always_comb begin
    sub = 32'(speed_level) * 32'(SPEEDUP_STEP);
    if (sub >= 32'(TICK_DIV - MIN_DIV)) period = 32'(MIN_DIV);
    else                                period = 32'(TICK_DIV) - sub;
  end

  assign step      = bus.enable && !bus.clear && (tick_cnt >= period - 32'd1);
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign shape_len = shape[0] ? 2'd2 : 2'd1;
  // Both rows of a two-row shape are identical; only the column mask differs.
  assign entry     = (state == ST_EMIT && emit_idx < shape_len) ?
                     COLS'(shape[1] ? 2'b11 : 2'b01) : '0;
  assign pass      = (field[ROWS-1] != '0) && (field[ROWS-2] == '0);

  assign bus.data_flat    = ~field;
  assign bus.step_pulse   = step;
  assign bus.passed_count = passed_count;
  assign bus.speed_level  = speed_level;

  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0)           lfsr <= LFSR_SEED;
    else if (bus.enable) lfsr <= lfsr_next;
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      field        <= '0;
      tick_cnt     <= '0;
      state        <= ST_GAP;
      gap_cnt      <= 8'(GAP_MIN);
      next_gap     <= 8'(GAP_MIN);
      type_idx     <= '0;
      shape        <= '0;
      emit_idx     <= '0;
      passed_count <= '0;
      every_cnt    <= '0;
      speed_level  <= '0;
    end else if (bus.clear) begin
      field        <= '0;
      tick_cnt     <= '0;
      state        <= ST_GAP;
      gap_cnt      <= 8'(GAP_MIN);
      next_gap     <= 8'(GAP_MIN);
      type_idx     <= '0;
      shape        <= '0;
      emit_idx     <= '0;
      passed_count <= '0;
      every_cnt    <= '0;
      speed_level  <= '0;
    end else if (bus.enable) begin
      if (!step) begin
        tick_cnt <= tick_cnt + 32'd1;
      end else begin
        tick_cnt <= '0;
        field    <= {field[ROWS-2:0], entry};

        if (pass && passed_count != 8'd255) begin
          passed_count <= passed_count + 8'd1;
          if (every_cnt == 8'(SPEEDUP_EVERY - 1)) begin
            every_cnt <= '0;
            if (speed_level != 4'd15) speed_level <= speed_level + 4'd1;
          end else begin
            every_cnt <= every_cnt + 8'd1;
          end
        end

        case (state)
          // The blank step that closes EMIT is the first gap row, so GAP picks
          // on the step that would bring gap_cnt down to 1.
          ST_GAP: begin
            if (gap_cnt <= 8'd2) begin
              state    <= ST_EMIT;
              emit_idx <= '0;
              if (RANDOM != 0) begin
                shape    <= lfsr[1:0];
                next_gap <= 8'(GAP_MIN) + {6'd0, lfsr[3:2]};
              end else begin
                shape    <= type_idx;
                type_idx <= type_idx + 2'd1;
                next_gap <= 8'(GAP_MIN);
              end
            end else begin
              gap_cnt <= gap_cnt - 8'd1;
            end
          end
          default: begin
            if (emit_idx < shape_len) begin
              emit_idx <= emit_idx + 2'd1;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= next_gap;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_obstacle_scroller.sv
// Scoreboard bench: a row-level field model predicts every frame, step spacing,
// pass count and speed level for a fixed-rotation and an LFSR-driven instance.
module tb_obstacle_scroller;
  localparam int          ROWS  = 7;
  localparam int          COLS  = 5;
  localparam int          TICK  = 4;
  localparam int          MIND  = 2;
  localparam int          STEP  = 1;
  localparam int          EVERY = 2;
  localparam int          GAPM  = 2;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [ROWS*COLS-1:0] ONES = '1;

  logic clk = 1'b0;
  logic key0 = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  obstacle_scroller_if #(.ROWS(ROWS), .COLS(COLS)) if0 ();
  obstacle_scroller_if #(.ROWS(ROWS), .COLS(COLS)) if1 ();
  assign if0.enable = enable;
  assign if0.clear  = clear;
  assign if1.enable = enable;
  assign if1.clear  = clear;

  obstacle_scroller #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK), .MIN_DIV(MIND),
    .SPEEDUP_STEP(STEP), .SPEEDUP_EVERY(EVERY), .GAP_MIN(GAPM), .RANDOM(0), .LFSR_SEED(SEED))
    u0 (.MAX10_CLK1_50(clk), .KEY0(key0), .bus(if0));
  obstacle_scroller #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK), .MIN_DIV(MIND),
    .SPEEDUP_STEP(STEP), .SPEEDUP_EVERY(EVERY), .GAP_MIN(GAPM), .RANDOM(1), .LFSR_SEED(SEED))
    u1 (.MAX10_CLK1_50(clk), .KEY0(key0), .bus(if1));

  logic [ROWS*COLS-1:0] df;
  logic                 sp;
  logic [7:0]           pc;
  logic [3:0]           sl;
  assign df = sel ? if1.data_flat    : if0.data_flat;
  assign sp = sel ? if1.step_pulse   : if0.step_pulse;
  assign pc = sel ? if1.passed_count : if0.passed_count;
  assign sl = sel ? if1.speed_level  : if0.speed_level;

  // Reference LFSR: 16-bit Galois, x^16+x^14+x^13+x^11, runs while enabled.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge key0) begin
    if (!key0)       m_lfsr <= SEED;
    else if (enable) m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  logic [COLS-1:0]      m_field [ROWS];
  logic [COLS-1:0]      eq [$];
  bit                   pq [$];
  logic [ROWS*COLS-1:0] sbq [$];
  logic [ROWS*COLS-1:0] last_frame;
  int m_cnt, m_spd, m_type, exp_gap, step_no;
  int n_cmp = 0;
  int n_bad = 0;
  bit lost;

  function automatic int m_period();
    int p;
    p = TICK - m_spd * STEP;
    return (p < MIND) ? MIND : p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ROWS; k++) m_field[k] = '0;
    m_cnt = 0; m_spd = 0; m_type = 0; step_no = 0; lost = 0;
    eq.delete(); pq.delete(); sbq.delete();
    for (int i = 0; i < GAPM - 1; i++) begin
      eq.push_back('0);
      pq.push_back(i == GAPM - 2);
    end
    last_frame = ONES;
    exp_gap = TICK - 1;
  endtask

  // Queue the rows of the next shape followed by its gap; the last gap row is the next pick.
  task automatic model_pick();
    int t, g;
    logic [COLS-1:0] mk;
    t = sel ? int'(m_lfsr[1:0]) : m_type;
    m_type = (m_type + 1) % 4;
    g = sel ? GAPM + int'(m_lfsr[3:2]) : GAPM;
    mk = (t >= 2) ? 5'b00011 : 5'b00001;
    repeat ((t % 2 == 1) ? 2 : 1) begin
      eq.push_back(mk);
      pq.push_back(1'b0);
    end
    for (int i = 0; i < g; i++) begin
      eq.push_back('0);
      pq.push_back(i == g - 1);
    end
  endtask

  task automatic model_step();
    logic [COLS-1:0]      ent;
    logic [ROWS*COLS-1:0] f;
    bit                   pk;
    ent = eq.pop_front();
    pk  = pq.pop_front();
    if (pk) model_pick();
    if (m_field[ROWS-1] != '0 && m_field[ROWS-2] == '0 && m_cnt < 255) begin
      m_cnt++;
      if (m_cnt % EVERY == 0 && m_spd < 15) m_spd++;
    end
    for (int k = ROWS - 1; k > 0; k--) m_field[k] = m_field[k-1];
    m_field[0] = ent;
    for (int k = 0; k < ROWS; k++) f[k*COLS +: COLS] = ~m_field[k];
    sbq.push_back(f);
  endtask

  task automatic one_step();
    int k;
    logic [ROWS*COLS-1:0] ef;
    if (lost) return;
    k = 0;
    do begin @(negedge clk); k++; end while (!sp && k < 64);
    n_cmp++;
    if (!sp) begin
      n_bad++; lost = 1;
      $display("FAIL step_timeout: step %0d not seen after %0d clks", step_no + 1, k);
      return;
    end
    if (k != exp_gap) begin
      n_bad++;
      $display("FAIL step_gap: step %0d after %0d clks, want %0d", step_no + 1, k, exp_gap);
    end
    model_step();
    step_no++;
    @(negedge clk);
    ef = sbq.pop_front();
    last_frame = ef;
    n_cmp++;
    if (df !== ef) begin
      n_bad++;
      $display("FAIL frame: step %0d got %h want %h", step_no, df, ef);
    end
    n_cmp++;
    if (pc !== 8'(m_cnt) || sl !== 4'(m_spd)) begin
      n_bad++;
      $display("FAIL counters: step %0d got pc=%0d sl=%0d want pc=%0d sl=%0d",
               step_no, pc, sl, m_cnt, m_spd);
    end
    exp_gap = m_period() - 1;
  endtask

  task automatic test_reset();
    key0 = 1'b0; enable = 1'b0; clear = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (if0.data_flat !== ONES || if1.data_flat !== ONES) begin
      n_bad++; $display("FAIL reset_frame: got %h/%h want %h", if0.data_flat, if1.data_flat, ONES);
    end
    n_cmp++;
    if (sp !== 1'b0 || pc !== 8'd0 || sl !== 4'd0) begin
      n_bad++; $display("FAIL reset_outputs: got sp=%b pc=%0d sl=%0d want 0/0/0", sp, pc, sl);
    end
    key0 = 1'b1; enable = 1'b1;
    model_reset();
  endtask

  task automatic test_scroll();
    logic [COLS-1:0] r1;
    for (int s = 1; s <= 24; s++) begin
      one_step();
      if (lost) return;
      r1 = df[COLS-1:0];
      if (s == 2) begin
        n_cmp++;
        if (r1 !== 5'b11110) begin n_bad++; $display("FAIL row1_small: got %b want 11110", r1); end
      end
      if (s == 3) begin
        n_cmp++;
        if (r1 !== 5'b11111) begin n_bad++; $display("FAIL row1_gap: got %b want 11111", r1); end
      end
      if (s == 9) begin
        n_cmp++;
        if (pc !== 8'd1) begin n_bad++; $display("FAIL first_pass: got %0d want 1", pc); end
      end
      if (s == 13) begin
        n_cmp++;
        if (sl !== 4'd1) begin n_bad++; $display("FAIL speed_up: got %0d want 1", sl); end
      end
    end
  endtask

  task automatic test_clear();
    int k;
    k = 0;
    while (!sp && k < 64) begin @(negedge clk); k++; end
    n_cmp++;
    if (!sp) begin n_bad++; $display("FAIL clear_wait: no step within %0d clks", k); end
    clear = 1'b1;
    #1;
    n_cmp++;
    if (sp !== 1'b0) begin n_bad++; $display("FAIL clear_pulse: got %b want 0", sp); end
    @(negedge clk);
    clear = 1'b0;
    n_cmp++;
    if (df !== ONES || pc !== 8'd0 || sl !== 4'd0) begin
      n_bad++; $display("FAIL clear_state: got df=%h pc=%0d sl=%0d want %h/0/0", df, pc, sl, ONES);
    end
    model_reset();
    repeat (3) one_step();
  endtask

  task automatic test_pause();
    bit bad;
    one_step();
    @(negedge clk);
    enable = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (sp !== 1'b0 || df !== last_frame) bad = 1;
    end
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL pause_hold: got df=%h sp=%b want %h/0", df, sp, last_frame); end
    enable = 1'b1;
    exp_gap = m_period() - 2;
    one_step();
  endtask

  task automatic test_reset_mid_emit();
    while (step_no < 5 && !lost) one_step();
    #2 key0 = 1'b0;
    #1;
    n_cmp++;
    if (df !== ONES || sp !== 1'b0 || pc !== 8'd0 || sl !== 4'd0) begin
      n_bad++; $display("FAIL async_reset: got df=%h sp=%b pc=%0d sl=%0d want %h/0/0/0", df, sp, pc, sl, ONES);
    end
    @(negedge clk);
    key0 = 1'b1;
    model_reset();
    repeat (4) one_step();
  endtask

  task automatic test_random();
    @(negedge clk);
    sel = 1'b1;
    key0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (df !== ONES) begin n_bad++; $display("FAIL random_reset: got %h want %h", df, ONES); end
    key0 = 1'b1;
    model_reset();
    repeat (30) one_step();
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_clear();
    test_pause();
    test_reset_mid_emit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
